// File: rtl/branch_predict_unit.sv
// Branch target buffer with 2-bit saturating direction counters.
// Fetch looks up combinationally; execute resolves and trains the table on the next edge.
module branch_predict_unit #(
   parameter int PC_W  = 9,
   parameter int IDX_W = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [PC_W-1:0]  f_pc,
   output logic             f_pred_taken,
   output logic [31:0]      f_pred_target,
   input  logic             e_valid,
   input  logic [PC_W-1:0]  e_pc,
   input  logic             e_branch,
   input  logic             e_jump,
   input  logic             e_jumpreg,
   input  logic             e_cond,
   input  logic [31:0]      e_target,
   input  logic             e_pred_taken,
   input  logic [31:0]      e_pred_target,
   output logic             e_mispredict,
   output logic [31:0]      e_redirect_pc,
   output logic [CNT_W-1:0] stat_branches,
   output logic [CNT_W-1:0] stat_mispred
);
   localparam int TAG_W = PC_W - IDX_W - 2;
   localparam int DEPTH = 1 << IDX_W;

   logic             valid_q  [DEPTH];
   logic [TAG_W-1:0] tag_q    [DEPTH];
   logic [31:0]      target_q [DEPTH];
   logic [1:0]       ctr_q    [DEPTH];

   logic [IDX_W-1:0] f_idx, e_idx;
   logic [TAG_W-1:0] f_tag, e_tag;
   logic             f_hit, e_hit, act_taken;
   logic [31:0]      pc4;
   logic             unused_pc_bits;

   // Instructions are word aligned, so the low PC bits never reach the table.
   assign unused_pc_bits = ^f_pc[1:0];

   assign f_idx = f_pc[IDX_W+1:2];
   assign f_tag = f_pc[PC_W-1:IDX_W+2];
   assign e_idx = e_pc[IDX_W+1:2];
   assign e_tag = e_pc[PC_W-1:IDX_W+2];

   assign f_hit         = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
   assign f_pred_taken  = f_hit && ctr_q[f_idx][1];
   assign f_pred_target = f_pred_taken ? target_q[f_idx] : 32'd0;

   assign e_hit     = valid_q[e_idx] && (tag_q[e_idx] == e_tag);
   assign act_taken = (e_branch && e_cond) || e_jump;
   assign pc4       = {{(32-PC_W){1'b0}}, e_pc} + 32'd4;

   assign e_mispredict  = reset && e_valid &&
                          ((e_pred_taken != act_taken) ||
                           (act_taken && (e_pred_target != e_target)));
   assign e_redirect_pc = act_taken ? e_target : pc4;

   // Next contents for the single entry addressed by e_pc this cycle.
   logic             wr_en;
   logic             wr_valid;
   logic [TAG_W-1:0] wr_tag;
   logic [31:0]      wr_target;
   logic [1:0]       wr_ctr;

   always_comb begin
      wr_en     = 1'b0;
      wr_valid  = valid_q[e_idx];
      wr_tag    = tag_q[e_idx];
      wr_target = target_q[e_idx];
      wr_ctr    = ctr_q[e_idx];
      if (e_valid) begin
         if (e_jump) begin
            if (!e_jumpreg) begin
               wr_en     = 1'b1;
               wr_valid  = 1'b1;
               wr_tag    = e_tag;
               wr_target = e_target;
               wr_ctr    = 2'b11;
            end else if (e_hit) begin
               // Register-indirect targets are not stable enough to cache.
               wr_en    = 1'b1;
               wr_valid = 1'b0;
            end
         end else if (e_branch) begin
            if (e_hit) begin
               wr_en = 1'b1;
               if (e_cond) begin
                  wr_ctr    = (ctr_q[e_idx] == 2'b11) ? 2'b11 : ctr_q[e_idx] + 2'b01;
                  wr_target = e_target;
               end else begin
                  wr_ctr = (ctr_q[e_idx] == 2'b00) ? 2'b00 : ctr_q[e_idx] - 2'b01;
               end
            end else if (e_cond) begin
               wr_en     = 1'b1;
               wr_valid  = 1'b1;
               wr_tag    = e_tag;
               wr_target = e_target;
               wr_ctr    = 2'b10;
            end
         end else if (e_hit) begin
            // A non-control instruction hitting an entry means the entry is a stale alias.
            wr_en    = 1'b1;
            wr_valid = 1'b0;
         end
      end
   end

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic             valid_reg;
      logic [TAG_W-1:0] tag_reg;
      logic [31:0]      target_reg;
      logic [1:0]       ctr_reg;

      always_ff @(posedge clk) begin
         if (!reset) begin
            valid_reg  <= 1'b0;
            tag_reg    <= '0;
            target_reg <= 32'd0;
            ctr_reg    <= 2'b00;
         end else if (wr_en && (e_idx == IDX_W'(gi))) begin
            valid_reg  <= wr_valid;
            tag_reg    <= wr_tag;
            target_reg <= wr_target;
            ctr_reg    <= wr_ctr;
         end
      end

      assign valid_q[gi]  = valid_reg;
      assign tag_q[gi]    = tag_reg;
      assign target_q[gi] = target_reg;
      assign ctr_q[gi]    = ctr_reg;
   end

   logic [CNT_W-1:0] stat_branches_reg, stat_mispred_reg;

   always_ff @(posedge clk) begin
      if (!reset) begin
         stat_branches_reg <= '0;
         stat_mispred_reg  <= '0;
      end else begin
         if (e_valid && (e_branch || e_jump) && (stat_branches_reg != '1))
            stat_branches_reg <= stat_branches_reg + 1'b1;
         if (e_mispredict && (stat_mispred_reg != '1))
            stat_mispred_reg <= stat_mispred_reg + 1'b1;
      end
   end

   assign stat_branches = stat_branches_reg;
   assign stat_mispred  = stat_mispred_reg;
endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench for branch_predict_unit: a driver pushes model expectations,
// a monitor on the falling edge pops and compares them against the DUT outputs.
module tb_branch_predict_unit;
   localparam int PC_W    = 9;
   localparam int IDX_W   = 4;
   localparam int CNT_W   = 6;
   localparam int DEPTH   = 1 << IDX_W;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             reset;
   logic [PC_W-1:0]  f_pc;
   logic             f_pred_taken;
   logic [31:0]      f_pred_target;
   logic             e_valid;
   logic [PC_W-1:0]  e_pc;
   logic             e_branch, e_jump, e_jumpreg, e_cond;
   logic [31:0]      e_target;
   logic             e_pred_taken;
   logic [31:0]      e_pred_target;
   logic             e_mispredict;
   logic [31:0]      e_redirect_pc;
   logic [CNT_W-1:0] stat_branches, stat_mispred;

   always #5 clk = ~clk;

   branch_predict_unit #(.PC_W(PC_W), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset),
      .f_pc(f_pc), .f_pred_taken(f_pred_taken), .f_pred_target(f_pred_target),
      .e_valid(e_valid), .e_pc(e_pc), .e_branch(e_branch), .e_jump(e_jump),
      .e_jumpreg(e_jumpreg), .e_cond(e_cond), .e_target(e_target),
      .e_pred_taken(e_pred_taken), .e_pred_target(e_pred_target),
      .e_mispredict(e_mispredict), .e_redirect_pc(e_redirect_pc),
      .stat_branches(stat_branches), .stat_mispred(stat_mispred)
   );

   typedef struct {
      logic        pt;
      logic [31:0] ptgt;
      logic        mp;
      logic [31:0] rpc;
      int unsigned sb;
      int unsigned sm;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_bad = 0;

   // Reference table: plain per-slot records, counters as integers.
   bit          m_v   [DEPTH];
   int unsigned m_tag [DEPTH];
   logic [31:0] m_tgt [DEPTH];
   int          m_ctr [DEPTH];
   int unsigned m_sb, m_sm;

   function automatic int unsigned idx_of(input int unsigned pc);
      return (pc / 4) % DEPTH;
   endfunction

   function automatic int unsigned tag_of(input int unsigned pc);
      return pc / (4 * DEPTH);
   endfunction

   function automatic bit m_hit(input int unsigned pc);
      return m_v[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
   endfunction

   function automatic bit m_taken(input int unsigned pc);
      return m_hit(pc) && (m_ctr[idx_of(pc)] >= 2);
   endfunction

   function automatic logic [31:0] m_target(input int unsigned pc);
      return m_taken(pc) ? m_tgt[idx_of(pc)] : 32'd0;
   endfunction

   task automatic m_clear();
      for (int i = 0; i < DEPTH; i++) begin
         m_v[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 0;
      end
      m_sb = 0;
      m_sm = 0;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("f_pred_taken",  {31'd0, f_pred_taken}, {31'd0, e.pt});
            check("f_pred_target", f_pred_target, e.ptgt);
            check("e_mispredict",  {31'd0, e_mispredict}, {31'd0, e.mp});
            check("e_redirect_pc", e_redirect_pc, e.rpc);
            check("stat_branches", 32'(stat_branches), e.sb);
            check("stat_mispred",  32'(stat_mispred), e.sm);
         end
      end
   end

   task automatic step(input bit rst, input int unsigned fpc, input bit ev,
                       input int unsigned epc, input bit br, input bit jmp,
                       input bit jr, input bit cond, input logic [31:0] tgt,
                       input bit pt, input logic [31:0] ptgt);
      exp_t        e;
      bit          act;
      bit          hit;
      int unsigned i;
      @(posedge clk);
      #1;
      reset = rst; f_pc = PC_W'(fpc); e_valid = ev; e_pc = PC_W'(epc);
      e_branch = br; e_jump = jmp; e_jumpreg = jr; e_cond = cond;
      e_target = tgt; e_pred_taken = pt; e_pred_target = ptgt;

      act    = (br && cond) || jmp;
      e.pt   = m_taken(fpc);
      e.ptgt = m_target(fpc);
      e.mp   = rst && ev && ((pt != act) || (act && ptgt != tgt));
      e.rpc  = act ? tgt : (epc + 32'd4);
      e.sb   = m_sb;
      e.sm   = m_sm;
      exp_q.push_back(e);

      // Advance the model to what the next edge will produce.
      if (!rst) begin
         m_clear();
      end else if (ev) begin
         if ((br || jmp) && m_sb < CNT_MAX) m_sb++;
         if (e.mp && m_sm < CNT_MAX) m_sm++;
         i   = idx_of(epc);
         hit = m_hit(epc);
         if (jmp) begin
            if (!jr) begin
               m_v[i] = 1; m_tag[i] = tag_of(epc); m_tgt[i] = tgt; m_ctr[i] = 3;
            end else if (hit) begin
               m_v[i] = 0;
            end
         end else if (br) begin
            if (hit) begin
               if (cond) begin
                  m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
                  m_tgt[i] = tgt;
               end else begin
                  m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
               end
            end else if (cond) begin
               m_v[i] = 1; m_tag[i] = tag_of(epc); m_tgt[i] = tgt; m_ctr[i] = 2;
            end
         end else if (hit) begin
            m_v[i] = 0;
         end
      end
   endtask

   // Resolution carrying the prediction fetch would have made for the same PC.
   task automatic resolve(input int unsigned pc, input bit br, input bit jmp,
                          input bit jr, input bit cond, input logic [31:0] tgt);
      step(1, pc, 1, pc, br, jmp, jr, cond, tgt, m_taken(pc), m_target(pc));
   endtask

   task automatic idle(input int unsigned fpc);
      step(1, fpc, 0, 0, 0, 0, 0, 0, 32'd0, 0, 32'd0);
   endtask

   initial begin : driver
      int unsigned pc, kind;
      bit          ev, br, jmp, jr, cond, pt, rst;
      logic [31:0] tgt, ptgt;
      int          drain;

      reset = 1'b0; f_pc = '0; e_valid = 1'b0; e_pc = '0;
      e_branch = 1'b0; e_jump = 1'b0; e_jumpreg = 1'b0; e_cond = 1'b0;
      e_target = 32'd0; e_pred_taken = 1'b0; e_pred_target = 32'd0;
      m_clear();

      // Cold table, not-taken branch, then a taken one that allocates.
      idle(32'h040);
      resolve(32'h040, 1, 0, 0, 0, 32'h010);
      idle(32'h040);
      resolve(32'h040, 1, 0, 0, 1, 32'h010);
      idle(32'h040);
      resolve(32'h040, 1, 0, 0, 0, 32'h010);
      resolve(32'h040, 1, 0, 0, 0, 32'h010);
      idle(32'h040);

      // Counter saturation and hysteresis.
      repeat (4) resolve(32'h040, 1, 0, 0, 1, 32'h018);
      resolve(32'h040, 1, 0, 0, 0, 32'h018);
      idle(32'h040);
      resolve(32'h040, 1, 0, 0, 0, 32'h018);
      idle(32'h040);

      // JAL allocation, JALR invalidation.
      resolve(32'h080, 0, 1, 0, 0, 32'h100);
      idle(32'h080);
      resolve(32'h080, 0, 1, 1, 0, 32'h1f4);
      idle(32'h080);

      // Aliasing eviction, tag miss, wrong-target mispredict, stale alias.
      resolve(32'h040, 1, 0, 0, 1, 32'h020);
      resolve(32'h080, 1, 0, 0, 1, 32'h030);
      idle(32'h040);
      idle(32'h080);
      step(1, 32'h080, 1, 32'h080, 1, 0, 0, 1, 32'h034, 1, 32'h030);
      idle(32'h080);
      resolve(32'h080, 0, 0, 0, 0, 32'h0);
      idle(32'h080);

      // Statistics saturation with always-mispredicting branches.
      repeat ((1 << CNT_W) + 3) step(1, 32'h100, 1, 32'h100, 1, 0, 0, 0, 32'h0, 1, 32'h008);
      idle(32'h100);

      // Mid-stream reset discards the pending update.
      resolve(32'h0c4, 0, 1, 0, 0, 32'h050);
      step(0, 32'h0c4, 1, 32'h0c8, 1, 0, 0, 1, 32'h060, 0, 32'h0);
      idle(32'h0c4);
      idle(32'h0c8);

      // Randomized traffic over a small PC window so entries get reused.
      repeat (900) begin
         pc   = 4 * $urandom_range(0, 47);
         kind = $urandom_range(0, 9);
         ev   = ($urandom_range(0, 7) != 0);
         br   = (kind <= 4) || (kind == 9);
         jmp  = (kind >= 5 && kind <= 7) || (kind == 9);
         jr   = (kind == 7) || (kind == 9 && $urandom_range(0, 1) == 1);
         cond = $urandom_range(0, 1);
         tgt  = ($urandom_range(0, 3) == 0) ? m_tgt[idx_of(pc)] : ($urandom & 32'h1fc);
         if ($urandom_range(0, 4) != 0) begin
            pt   = m_taken(pc);
            ptgt = m_target(pc);
         end else begin
            pt   = $urandom_range(0, 1);
            ptgt = $urandom & 32'h1fc;
         end
         rst = ($urandom_range(0, 99) != 0);
         step(rst, 4 * $urandom_range(0, 47), ev, pc, br, jmp, jr, cond, tgt, pt, ptgt);
      end

      drain = 0;
      while (exp_q.size() > 0 && drain < 20) begin
         @(posedge clk);
         drain++;
      end
      if (exp_q.size() > 0) begin
         n_vec++;
         n_bad++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Parametrised branch target buffer with 2-bit saturating direction counters, used as the successor to the combinational branch-resolution logic. The fetch stage looks it up with the current PC and gets a registered-state prediction in the same cycle. The execute stage reports the resolved outcome, and the block returns a mispredict flag and redirect PC while training its tables on the next clock edge. It also keeps saturating branch and mispredict statistics counters.

## Interface

Parameters:
- PC_W, 9, instruction address width; PCs are zero-extended to 32 bits for all arithmetic.
- IDX_W, 4, index width; the table has 2**IDX_W entries. Constraint: PC_W >= IDX_W + 3.
- CNT_W, 16, width of each statistics counter.
- Derived: TAG_W = PC_W - IDX_W - 2. Index = pc[IDX_W+1:2]; tag = pc[PC_W-1:IDX_W+2].

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- f_pc  in  PC_W  fetch-stage PC.
- f_pred_taken  out  1  prediction for f_pc: predicted taken.
- f_pred_target  out  32  predicted target; 0 when f_pred_taken=0.
- e_valid  in  1  execute-stage instruction valid.
- e_pc  in  PC_W  PC of the execute-stage instruction.
- e_branch  in  1  conditional branch.
- e_jump  in  1  unconditional jump (JAL or JALR).
- e_jumpreg  in  1  with e_jump, the jump is JALR.
- e_cond  in  1  branch condition result (ALU bit 0).
- e_target  in  32  resolved target (PC+imm, or ALU result for JALR).
- e_pred_taken  in  1  f_pred_taken carried down the pipeline with this instruction.
- e_pred_target  in  32  f_pred_target carried down the pipeline with this instruction.
- e_mispredict  out  1  prediction was wrong; flush and redirect.
- e_redirect_pc  out  32  correct next PC.
- stat_branches  out  CNT_W  count of resolved control instructions.
- stat_mispred  out  CNT_W  count of mispredicts.

## Operation

Entry contents:
- Each entry holds valid, tag[TAG_W], target[32] and ctr[2].

Lookup (combinational from table state):
- hit = valid[idx] && tag[idx] == f_pc tag.
- f_pred_taken = hit && ctr[1].
- f_pred_target = f_pred_taken ? target : 0.

Resolution (combinational):
- act_taken = (e_branch && e_cond) || e_jump.
- pc4 = {zero-extended e_pc} + 4, 32-bit, wraps modulo 2**32.
- e_mispredict = reset && e_valid && (e_pred_taken != act_taken || (act_taken && e_pred_target != e_target)).
- e_redirect_pc = act_taken ? e_target : pc4.

Update, at the clock edge when reset=1 and e_valid=1; hit is evaluated on e_pc:
- Conditional branch, hit: ctr increments if e_cond=1, decrements otherwise, saturating at 0 and 3. If e_cond=1, target <= e_target.
- Conditional branch, miss, e_cond=1: allocate. valid=1, tag, target=e_target, ctr=2'b10. The previous occupant is overwritten.
- Conditional branch, miss, e_cond=0: no change.
- JAL (e_jump=1, e_jumpreg=0): allocate or refresh with ctr=2'b11 and target=e_target.
- JALR (e_jump=1, e_jumpreg=1): never allocated. On a hit the entry is invalidated.
- Neither e_branch nor e_jump: on a hit (stale alias) the entry is invalidated.
- If e_branch and e_jump are both 1, e_jump takes precedence.

Statistics:
- stat_branches increments when e_valid && (e_branch || e_jump).
- stat_mispred increments when e_mispredict=1.
- Both counters saturate at all-ones.

Reset (reset=0 at an edge):
- All valid bits, ctr and target cleared; statistics cleared.
- After that edge: f_pred_taken=0 and f_pred_target=0.
- e_mispredict is forced to 0 while reset=0.
- Reset asserted mid-stream discards any pending update that cycle.

## Timing

- Lookup and resolution are zero-latency combinational outputs.
- Table updates become visible to lookup on the cycle after the update edge.
- Same-cycle lookup and update to the same index: lookup returns the pre-update contents. There is no bypass.
- Statistics reflect events up to the previous edge, so there is 1-cycle latency.
- No backpressure. One resolution is accepted per cycle.

## Test plan

- Reset, then f_pc=0x040 -> f_pred_taken=0, f_pred_target=0, stats=0. Resolving a not-taken branch at 0x040 -> no mispredict, redirect=0x44, f_pred_taken stays 0 next cycle.
- Taken branch at e_pc=0x040, e_target=0x010, pred=0 -> e_mispredict=1, redirect=0x010. Next cycle f_pc=0x040 -> f_pred_taken=1, target=0x010 (ctr=2). Two not-taken resolutions -> f_pred_taken=0.
- Counter saturation: taken, then 3 more taken (ctr=3), then 1 not-taken -> still predicts taken; a second not-taken -> predicts not taken.
- JAL at 0x080 to 0x100 -> allocated with ctr=3. JALR hitting an entry -> entry invalidated, and redirect equals e_target.
- Aliasing: entries at 0x040 and 0x040 + 2**(IDX_W+2) -> the second allocation evicts the first. Tag mismatch -> no prediction. Correct prediction with a wrong target -> e_mispredict=1.
- Statistics: drive 2**CNT_W+3 mispredicting branches with a reduced CNT_W -> both counters hold at all-ones. Assert reset mid-stream -> table and counters cleared at that edge.
